// File: rtl/pend_request_bank_pkg.sv
// Shared types and helpers for the pending request bank.
package pend_request_bank_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int AGE_LIMIT_DEFAULT = 15;

  // Index width for n slots; a single slot still gets a one-bit index.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pend_slot.sv
// One request slot: EMPTY/FULL state, payload register and, with PEND_AGE_EN
// defined, a saturating age counter that flags the slot once it has waited too long.
module pend_slot
  import pend_request_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32
`ifdef PEND_AGE_EN
  , parameter int AGE_LIMIT = AGE_LIMIT_DEFAULT
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] load_data,
  output slot_state_e           state,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  aged
);

  slot_state_e state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SLOT_EMPTY;
    else        state <= state_nxt;
  end

  // A load on the same edge as a pop wins: the slot stays FULL with new data.
  always_comb begin
    state_nxt = state;
    if (load)     state_nxt = SLOT_FULL;
    else if (pop) state_nxt = SLOT_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data <= '0;
    else if (load) data <= load_data;
  end

`ifdef PEND_AGE_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] age;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      age <= '0;
    else if (load || pop)
      age <= '0;
    else if (state == SLOT_FULL && age != AGE_W'(AGE_LIMIT))
      age <= age + 1'b1;
  end

  assign aged = (state == SLOT_FULL) && (age == AGE_W'(AGE_LIMIT));
`else
  assign aged = 1'b0;
`endif

endmodule

// File: rtl/pend_request_bank.sv
// Per-source holding bank feeding a priority multiplexer's select/data inputs.
// Optional anti-starvation aging is enabled by defining PEND_AGE_EN.
module pend_request_bank
  import pend_request_bank_pkg::*;
#(
  parameter  int SEL_WIDTH  = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int AGE_LIMIT  = AGE_LIMIT_DEFAULT,
  localparam int IDX_W      = calc_idx_w(SEL_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [SEL_WIDTH-1:0]            in_valid,
  input  logic [SEL_WIDTH*DATA_WIDTH-1:0] in_data,
  output logic [SEL_WIDTH-1:0]            in_ready,
  output logic [SEL_WIDTH-1:0]            pend_valid,
  output logic [SEL_WIDTH*DATA_WIDTH-1:0] pend_data,
  input  logic                            pop,
  input  logic [IDX_W-1:0]                pop_idx,
  output logic [IDX_W:0]                  occupancy,
  output logic                            err_pop
);

  if (AGE_LIMIT < 1) begin : g_bad_age_limit
    $error("pend_request_bank: AGE_LIMIT must be at least 1");
  end

  slot_state_e          slot_state [SEL_WIDTH];
  logic [SEL_WIDTH-1:0] full_vec;
  logic [SEL_WIDTH-1:0] pop_sel;
  logic [SEL_WIDTH-1:0] load_vec;
  logic [SEL_WIDTH-1:0] aged_vec;
  logic                 pop_valid;
  logic [IDX_W:0]       occ_nxt;

  // Handshake: a source transfers on in_valid[i] & in_ready[i]; in_ready depends
  // only on slot state and the pop in the same cycle, never on in_valid.
  for (genvar i = 0; i < SEL_WIDTH; i++) begin : g_slot
    assign full_vec[i] = (slot_state[i] == SLOT_FULL);
    assign pop_sel[i]  = pop && (pop_idx == IDX_W'(i));
    assign in_ready[i] = !full_vec[i] || pop_sel[i];
    assign load_vec[i] = in_valid[i] && in_ready[i];

    pend_slot #(
      .DATA_WIDTH(DATA_WIDTH)
`ifdef PEND_AGE_EN
      , .AGE_LIMIT(AGE_LIMIT)
`endif
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_vec[i]),
      .pop       (pop_sel[i] && full_vec[i]),
      .load_data (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .state     (slot_state[i]),
      .data      (pend_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .aged      (aged_vec[i])
    );
  end

  assign pop_valid = |(pop_sel & full_vec);

  // Aged slots, when present, hide every younger slot from the mux.
  assign pend_valid = (|aged_vec) ? aged_vec : full_vec;

  always_comb begin
    occ_nxt = occupancy;
    for (int i = 0; i < SEL_WIDTH; i++)
      occ_nxt = occ_nxt + {{IDX_W{1'b0}}, load_vec[i]};
    if (pop_valid)
      occ_nxt = occ_nxt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
      err_pop   <= 1'b0;
    end else begin
      occupancy <= occ_nxt;
      err_pop   <= pop && !pop_valid;
    end
  end

endmodule

// File: tb/tb_pend_request_bank.sv
// Directed plus randomized bench for pend_request_bank against a slot-array model.
module tb_pend_request_bank;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int W   = N * DW;
  localparam int LIM = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] in_valid = '0;
  logic [W-1:0] in_data = '0;
  logic [N-1:0] in_ready;
  logic [N-1:0] pend_valid;
  logic [W-1:0] pend_data;
  logic         pop = 1'b0;
  logic [1:0]   pop_idx = '0;
  logic [2:0]   occupancy;
  logic         err_pop;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one entry per slot.
  bit          m_full [N];
  logic [31:0] m_data [N];
  int          m_age  [N];
  bit          m_err;

  pend_request_bank #(.SEL_WIDTH(N), .DATA_WIDTH(DW), .AGE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pend_valid(pend_valid), .pend_data(pend_data),
    .pop(pop), .pop_idx(pop_idx), .occupancy(occupancy), .err_pop(err_pop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = !m_full[i] || (pop && pop_idx == i);
    return r;
  endfunction

  function automatic logic [N-1:0] exp_pend_valid();
    logic [N-1:0] f, a;
    for (int i = 0; i < N; i++) begin
      f[i] = m_full[i];
      a[i] = m_full[i] && (m_age[i] == LIM);
    end
`ifdef PEND_AGE_EN
    if (a != 0) return a;
`endif
    return f;
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_full[i];
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_data[i] = '0; m_age[i] = 0;
    end
    m_err = 0;
  endtask

  // Apply the rules to the inputs sampled on the edge just taken.
  task automatic model_edge();
    logic [N-1:0] rdy;
    bit valid_pop;
    rdy = exp_ready();
    valid_pop = pop && m_full[pop_idx];
    for (int i = 0; i < N; i++) begin
      bit ld, pp;
      ld = in_valid[i] && rdy[i];
      pp = pop && pop_idx == i && m_full[i];
      if (ld || pp) m_age[i] = 0;
      else if (m_full[i] && m_age[i] < LIM) m_age[i]++;
      if (ld) begin
        m_full[i] = 1;
        m_data[i] = in_data[i*DW +: DW];
      end else if (pp) m_full[i] = 0;
    end
    m_err = pop && !valid_pop;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".pend_valid"}, W'(pend_valid), W'(exp_pend_valid()));
    chk({tag, ".occupancy"}, W'(occupancy), W'(exp_count()));
    chk({tag, ".err_pop"}, W'(err_pop), W'(m_err));
    for (int i = 0; i < N; i++)
      if (m_full[i]) chk($sformatf("%s.data%0d", tag, i), W'(pend_data[i*DW +: DW]), W'(m_data[i]));
  endtask

  // One cycle: drive at posedge+1, check in_ready, clock, check outputs.
  task automatic step(input string tag, input logic [N-1:0] v, input logic [W-1:0] d,
                      input logic p, input logic [1:0] idx);
    in_valid = v; in_data = d; pop = p; pop_idx = idx;
    #1;
    chk({tag, ".in_ready"}, W'(in_ready), W'(exp_ready()));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [W-1:0] pack4(input logic [31:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  initial begin
    logic [W-1:0] rnd;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pend_valid", W'(pend_valid), '0);
    chk("reset.pend_data", pend_data, '0);
    chk("reset.occupancy", W'(occupancy), '0);
    chk("reset.err_pop", W'(err_pop), '0);
    chk("reset.in_ready", W'(in_ready), W'(4'b1111));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("load0101", 4'b0101, pack4(32'hA0, 32'h0, 32'hA2, 32'h0), 1'b0, 2'd0);
    chk("load0101.slice2", W'(pend_data[2*DW +: DW]), W'(32'hA2));
    chk("load0101.occ", W'(occupancy), W'(2));
    step("hold2", 4'b0100, pack4(32'h0, 32'h0, 32'hC2, 32'h0), 1'b0, 2'd0);
    chk("hold2.slice2", W'(pend_data[2*DW +: DW]), W'(32'hA2));
    step("popload2", 4'b0100, pack4(32'h0, 32'h0, 32'hB2, 32'h0), 1'b1, 2'd2);
    chk("popload2.slice2", W'(pend_data[2*DW +: DW]), W'(32'hB2));
    step("errpop3", 4'b0000, '0, 1'b1, 2'd3);
    chk("errpop3.err", W'(err_pop), W'(1));
    step("errclear", 4'b0000, '0, 1'b0, 2'd0);
    chk("errclear.err", W'(err_pop), W'(0));

    step("fill", 4'b1111, pack4(32'h10, 32'h11, 32'h12, 32'h13), 1'b0, 2'd0);
    chk("fill.occ", W'(occupancy), W'(4));
    step("fullpop1", 4'b1111, pack4(32'h20, 32'h21, 32'h22, 32'h23), 1'b1, 2'd1);
    chk("fullpop1.data1", W'(pend_data[1*DW +: DW]), W'(32'h21));
    for (int i = 0; i < N; i++) begin
      step($sformatf("drain%0d", i), 4'b0000, '0, 1'b1, 2'(i));
      chk($sformatf("drain%0d.occ", i), W'(occupancy), W'(3 - i));
    end
    chk("drain.pend_valid", W'(pend_valid), '0);

    // Slot 3 left waiting while slot 0 churns.
    step("age.load", 4'b1001, pack4(32'h30, 32'h0, 32'h0, 32'h33), 1'b0, 2'd0);
    for (int c = 0; c < 5; c++)
      step($sformatf("age.churn%0d", c), 4'b0001, pack4(32'h40 + c, 0, 0, 0), 1'b1, 2'd0);
`ifdef PEND_AGE_EN
    chk("age.mask", W'(pend_valid), W'(4'b1000));
`else
    chk("age.nomask", W'(pend_valid), W'(4'b1001));
`endif
    step("age.pop3", 4'b0000, '0, 1'b1, 2'd3);
    chk("age.after_pop3", W'(pend_valid), W'(4'b0001));

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) rnd[i*DW +: DW] = $urandom;
      step($sformatf("rand%0d", c), 4'($urandom_range(0, 15)), rnd,
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    step("pre_rst", 4'b0111, pack4(32'h50, 32'h51, 32'h52, 32'h0), 1'b1, 2'd3);
    in_valid = '0; pop = 1'b1; pop_idx = 2'd3;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.pend_valid", W'(pend_valid), '0);
    chk("midrst.occupancy", W'(occupancy), '0);
    chk("midrst.err_pop", W'(err_pop), '0);
    pop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
